// File: rtl/wb_hostbridge_pkg.sv
// Shared types and constants for the Wishbone / host-bus bridge.
// The host bus is big-endian: byte offset 0 lands in bits 31:24 of a word.
package wb_hostbridge_pkg;

   typedef enum logic [1:0] {
      H_IDLE,
      H_WRITE,
      H_READ
   } host_state_t;

   typedef enum logic {
      W_IDLE,
      W_ACK
   } wb_state_t;

   localparam logic [12:0] mbox_byte_addr = 13'h1FFF;
   localparam int          byte_w         = 8;
   localparam int          num_lanes      = 4;
   localparam logic [1:0]  top_lane       = 2'd3;

   function automatic logic [1:0] host_lane(input logic [1:0] byte_off);
      return top_lane - byte_off;
   endfunction

endpackage

// File: rtl/wb_hostbridge_sync.sv
// Brings the active-low host strobes into the clk domain and flags
// the rising (deasserting) edges of the synchronized write and chip-select.
module hostbridge_sync #(
   parameter int sync_stages = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic cpu_nwe,
   input  logic cpu_noe,
   input  logic cpu_ncs,
   output logic nwe_s,
   output logic noe_s,
   output logic ncs_s,
   output logic nwe_rise,
   output logic ncs_rise
);

   // Bit order {ncs, noe, nwe}; all flops idle high so reset reads as "no access".
   logic [2:0] stage_reg [sync_stages];
   logic [2:0] prev_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < sync_stages; i++) begin
            stage_reg[i] <= '1;
         end
         prev_reg <= '1;
      end else begin
         stage_reg[0] <= {cpu_ncs, cpu_noe, cpu_nwe};
         for (int i = 1; i < sync_stages; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
         prev_reg <= stage_reg[sync_stages-1];
      end
   end

   assign nwe_s    = stage_reg[sync_stages-1][0];
   assign noe_s    = stage_reg[sync_stages-1][1];
   assign ncs_s    = stage_reg[sync_stages-1][2];
   assign nwe_rise = nwe_s & ~prev_reg[0];
   assign ncs_rise = ncs_s & ~prev_reg[2];

endmodule

// File: rtl/wb_hostbridge.sv
// Wishbone slave and asynchronous 8-bit host port sharing one 32-bit buffer.
// Host byte commits win arbitration; a host write to byte 0x1FFF raises intr.
module wb_hostbridge
   import wb_hostbridge_pkg::*;
#(
   parameter int adr_width   = 11,
   parameter int sync_stages = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   input  logic        wb_we_i,
   output logic        wb_ack_o,
   input  logic [12:0] cpu_addr,
   input  logic [7:0]  cpu_data_i,
   output logic [7:0]  cpu_data_o,
   output logic        cpu_data_oe,
   input  logic        cpu_nwe,
   input  logic        cpu_noe,
   input  logic        cpu_ncs,
   output logic        intr
);

   localparam int depth = 2 ** adr_width;

   logic                 nwe_s, noe_s, ncs_s, nwe_rise, ncs_rise;
   host_state_t          host_state_reg, host_state_next;
   wb_state_t            wb_state_reg, wb_state_next;
   logic                 host_commit, wb_accept, wb_write;
   logic [12:0]          cap_addr_reg, rd_addr_reg;
   logic [7:0]           cap_data_reg;
   logic [1:0]           rd_lane_reg;
   logic [adr_width-1:0] wb_word, host_rd_word, wr_word;
   logic [num_lanes-1:0] wr_en;
   logic [31:0]          wr_data, wb_q, host_q;
   logic [7:0]           host_byte;
   logic                 unused_bits;

   hostbridge_sync #(.sync_stages(sync_stages)) u_sync (
      .clk      (clk),
      .reset    (reset),
      .cpu_nwe  (cpu_nwe),
      .cpu_noe  (cpu_noe),
      .cpu_ncs  (cpu_ncs),
      .nwe_s    (nwe_s),
      .noe_s    (noe_s),
      .ncs_s    (ncs_s),
      .nwe_rise (nwe_rise),
      .ncs_rise (ncs_rise)
   );

   // Host address/data are only trusted once the synchronized strobes say so.
   always_ff @(posedge clk) begin
      if (!nwe_s) begin
         cap_addr_reg <= cpu_addr;
         cap_data_reg <= cpu_data_i;
      end
      rd_addr_reg <= cpu_addr;
      rd_lane_reg <= rd_addr_reg[1:0];
   end

   assign wb_word      = wb_adr_i[adr_width+1:2];
   assign host_rd_word = adr_width'(rd_addr_reg[12:2]);
   assign unused_bits  = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         host_state_reg <= H_IDLE;
         wb_state_reg   <= W_IDLE;
      end else begin
         host_state_reg <= host_state_next;
         wb_state_reg   <= wb_state_next;
      end
   end

   always_comb begin
      host_state_next = host_state_reg;
      host_commit     = 1'b0;
      case (host_state_reg)
         H_IDLE: begin
            if (!ncs_s && !nwe_s) begin
               host_state_next = H_WRITE;
            end else if (!ncs_s && !noe_s) begin
               host_state_next = H_READ;
            end
         end
         H_WRITE: begin
            if (ncs_rise) begin
               host_state_next = H_IDLE;
            end else if (nwe_rise) begin
               host_commit     = 1'b1;
               host_state_next = H_IDLE;
            end
         end
         H_READ: begin
            if (noe_s || ncs_s) begin
               host_state_next = H_IDLE;
            end
         end
         default: host_state_next = H_IDLE;
      endcase
   end

   assign wb_accept = (wb_state_reg == W_IDLE) && wb_stb_i && wb_cyc_i && !host_commit;
   assign wb_write  = wb_accept && wb_we_i;

   always_comb begin
      wb_state_next = W_IDLE;
      if (wb_state_reg == W_IDLE && wb_accept) begin
         wb_state_next = W_ACK;
      end
   end

   assign wb_ack_o = (wb_state_reg == W_ACK);
   assign wb_dat_o = wb_ack_o ? wb_q : '0;

   // Single write port: a host commit pre-empts any Wishbone write that cycle.
   always_comb begin
      wr_en   = '0;
      wr_word = wb_word;
      wr_data = wb_dat_i;
      if (!reset) begin
         if (host_commit) begin
            wr_en[host_lane(cap_addr_reg[1:0])] = 1'b1;
            wr_word = adr_width'(cap_addr_reg[12:2]);
            wr_data = {num_lanes{cap_data_reg}};
         end else if (wb_write) begin
            wr_en = wb_sel_i;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < num_lanes; gi++) begin : g_lane
         logic [byte_w-1:0] mem [depth];
         logic [byte_w-1:0] wb_q_reg;
         logic [byte_w-1:0] host_q_reg;

         always_ff @(posedge clk) begin
            if (wr_en[gi]) begin
               mem[wr_word] <= wr_data[gi*byte_w +: byte_w];
            end
            wb_q_reg   <= mem[wb_word];
            host_q_reg <= mem[host_rd_word];
         end

         assign wb_q[gi*byte_w +: byte_w]   = wb_q_reg;
         assign host_q[gi*byte_w +: byte_w] = host_q_reg;
      end
   endgenerate

   assign host_byte = host_q[int'(host_lane(rd_lane_reg))*byte_w +: byte_w];

   // Drive the host bus only after the read pipeline has had a cycle to fill.
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_data_o  <= '0;
         cpu_data_oe <= 1'b0;
      end else if (host_state_reg == H_READ && host_state_next == H_READ) begin
         cpu_data_o  <= host_byte;
         cpu_data_oe <= 1'b1;
      end else begin
         cpu_data_oe <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         intr <= 1'b0;
      end else if (host_commit && cap_addr_reg == mbox_byte_addr) begin
         intr <= 1'b1;
      end else if (wb_write && wb_sel_i[0] && wb_word == '1) begin
         intr <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_hostbridge.sv
// Table-driven bench for wb_hostbridge with a scoreboard queue of expected
// read results, plus hand-written arbitration, mailbox, abort and reset sequences.
module tb_wb_hostbridge;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
   logic [12:0] cpu_addr;
   logic [7:0]  cpu_data_i, cpu_data_o;
   logic        cpu_data_oe, cpu_nwe, cpu_noe, cpu_ncs, intr;

   int checks   = 0;
   int failures = 0;

   typedef enum logic [1:0] {OP_HW, OP_HR, OP_WW, OP_WR} op_t;
   typedef struct {
      op_t         op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  sel;
   } vec_t;

   localparam int nv = 23;
   vec_t        vecs [nv];
   logic [31:0] exp_q [$];

   wb_hostbridge dut (
      .clk         (clk),
      .reset       (reset),
      .wb_adr_i    (wb_adr_i),
      .wb_dat_i    (wb_dat_i),
      .wb_dat_o    (wb_dat_o),
      .wb_sel_i    (wb_sel_i),
      .wb_stb_i    (wb_stb_i),
      .wb_cyc_i    (wb_cyc_i),
      .wb_we_i     (wb_we_i),
      .wb_ack_o    (wb_ack_o),
      .cpu_addr    (cpu_addr),
      .cpu_data_i  (cpu_data_i),
      .cpu_data_o  (cpu_data_o),
      .cpu_data_oe (cpu_data_oe),
      .cpu_nwe     (cpu_nwe),
      .cpu_noe     (cpu_noe),
      .cpu_ncs     (cpu_ncs),
      .intr        (intr)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic host_write(input logic [12:0] a, input logic [7:0] d);
      cpu_addr = a; cpu_data_i = d; cpu_ncs = 1'b0; cpu_nwe = 1'b0;
      repeat (5) @(posedge clk); #1;
      cpu_nwe = 1'b1;
      repeat (4) @(posedge clk); #1;
      cpu_ncs = 1'b1;
      repeat (4) @(posedge clk); #1;
      $display("txn host_write addr=%h data=%h", a, d);
   endtask

   task automatic host_read(input logic [12:0] a, output logic [7:0] d, output logic ok);
      cpu_addr = a; cpu_ncs = 1'b0; cpu_noe = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (cpu_data_oe) begin
            ok = 1'b1;
            break;
         end
      end
      d = cpu_data_o;
      cpu_noe = 1'b1; cpu_ncs = 1'b1;
      repeat (4) @(posedge clk); #1;
      chk("host_oe_release", {31'b0, cpu_data_oe}, 32'd0);
      $display("txn host_read addr=%h data=%h oe_seen=%0d", a, d, ok);
   endtask

   task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdat, output int lat);
      wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
      wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
      lat = 0;
      while (lat < 10) begin
         @(posedge clk); #1;
         lat++;
         if (wb_ack_o) break;
      end
      rdat = wb_dat_o;
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
      @(posedge clk); #1;
      chk("wb_ack_single", {31'b0, wb_ack_o}, 32'd0);
      $display("txn wb_%s adr=%h dat=%h sel=%b rdat=%h lat=%0d", we ? "write" : "read",
               adr, dat, sel, rdat, lat);
   endtask

   initial begin
      logic [31:0] rword, expw;
      logic [7:0]  rbyte;
      logic        ok;
      int          lat;

      vecs[0]  = '{OP_HW, 32'h0000, 32'h0000_00DE, 4'h0};
      vecs[1]  = '{OP_HW, 32'h0001, 32'h0000_00AD, 4'h0};
      vecs[2]  = '{OP_HW, 32'h0002, 32'h0000_00BE, 4'h0};
      vecs[3]  = '{OP_HW, 32'h0003, 32'h0000_00EF, 4'h0};
      vecs[4]  = '{OP_WR, 32'h0000, 32'hDEAD_BEEF, 4'hF};
      vecs[5]  = '{OP_WW, 32'h0014, 32'hFFFF_FFFF, 4'hF};
      vecs[6]  = '{OP_WW, 32'h0014, 32'h1122_3344, 4'b0101};
      vecs[7]  = '{OP_HR, 32'h0014, 32'h0000_00FF, 4'h0};
      vecs[8]  = '{OP_HR, 32'h0015, 32'h0000_0022, 4'h0};
      vecs[9]  = '{OP_HR, 32'h0016, 32'h0000_00FF, 4'h0};
      vecs[10] = '{OP_HR, 32'h0017, 32'h0000_0044, 4'h0};
      vecs[11] = '{OP_WW, 32'h2010, 32'hCAFE_F00D, 4'hF};
      vecs[12] = '{OP_WR, 32'h0010, 32'hCAFE_F00D, 4'hF};
      vecs[13] = '{OP_HR, 32'h0010, 32'h0000_00CA, 4'h0};
      vecs[14] = '{OP_HR, 32'h0013, 32'h0000_000D, 4'h0};
      vecs[15] = '{OP_WW, 32'h0020, 32'hAABB_CCDD, 4'hF};
      vecs[16] = '{OP_HW, 32'h0021, 32'h0000_0077, 4'h0};
      vecs[17] = '{OP_WR, 32'h0020, 32'hAA77_CCDD, 4'hF};
      vecs[18] = '{OP_WW, 32'h0030, 32'h0102_0304, 4'hF};
      vecs[19] = '{OP_WW, 32'h0030, 32'hF0F0_F0F0, 4'b1000};
      vecs[20] = '{OP_WR, 32'h0030, 32'hF002_0304, 4'hF};
      vecs[21] = '{OP_HR, 32'h0012, 32'h0000_00F0, 4'h0};
      vecs[22] = '{OP_HR, 32'h0003, 32'h0000_00EF, 4'h0};

      reset = 1'b1;
      wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
      cpu_addr = '0; cpu_data_i = '0;
      cpu_nwe = 1'b1; cpu_noe = 1'b1; cpu_ncs = 1'b1;
      repeat (4) @(posedge clk); #1;
      chk("rst_ack",   {31'b0, wb_ack_o}, 32'd0);
      chk("rst_wbdat", wb_dat_o, 32'd0);
      chk("rst_cpudo", {24'b0, cpu_data_o}, 32'd0);
      chk("rst_oe",    {31'b0, cpu_data_oe}, 32'd0);
      chk("rst_intr",  {31'b0, intr}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < nv; i++) begin
         case (vecs[i].op)
            OP_HW: host_write(vecs[i].addr[12:0], vecs[i].data[7:0]);
            OP_HR: begin
               exp_q.push_back(vecs[i].data);
               host_read(vecs[i].addr[12:0], rbyte, ok);
               chk($sformatf("v%0d_host_oe", i), {31'b0, ok}, 32'd1);
               expw = exp_q.pop_front();
               chk($sformatf("v%0d_host_data", i), {24'b0, rbyte}, expw);
            end
            OP_WW: begin
               wb_cycle(1'b1, vecs[i].addr, vecs[i].data, vecs[i].sel, rword, lat);
               chk($sformatf("v%0d_wb_wr_lat", i), lat, 32'd1);
            end
            default: begin
               exp_q.push_back(vecs[i].data);
               wb_cycle(1'b0, vecs[i].addr, 32'd0, vecs[i].sel, rword, lat);
               chk($sformatf("v%0d_wb_rd_lat", i), lat, 32'd1);
               expw = exp_q.pop_front();
               chk($sformatf("v%0d_wb_rd_data", i), rword, expw);
            end
         endcase
      end

      // Host nwe rise lands in the same cycle as a Wishbone read of that word.
      wb_cycle(1'b1, 32'h0040, 32'h0000_0000, 4'hF, rword, lat);
      cpu_addr = 13'h0040; cpu_data_i = 8'h99; cpu_ncs = 1'b0; cpu_nwe = 1'b0;
      repeat (5) @(posedge clk); #1;
      cpu_nwe = 1'b1;
      repeat (2) @(posedge clk); #1;
      exp_q.push_back(32'h9900_0000);
      wb_adr_i = 32'h0040; wb_sel_i = 4'hF; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
      lat = 0;
      while (lat < 10) begin
         @(posedge clk); #1;
         lat++;
         if (wb_ack_o) break;
      end
      rword = wb_dat_o;
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
      chk("coincide_lat", lat, 32'd2);
      expw = exp_q.pop_front();
      chk("coincide_data", rword, expw);
      $display("txn coincide_read rdat=%h lat=%0d", rword, lat);
      cpu_ncs = 1'b1;
      repeat (4) @(posedge clk); #1;

      // Mailbox: set by host byte 0x1FFF, cleared only by a write hitting sel[0] of word 0x7FF.
      host_write(13'h1FFF, 8'h5A);
      chk("mbox_set", {31'b0, intr}, 32'd1);
      exp_q.push_back(32'h0000_005A);
      host_read(13'h1FFF, rbyte, ok);
      expw = exp_q.pop_front();
      chk("mbox_byte", {24'b0, rbyte}, expw);
      wb_cycle(1'b1, 32'h0000_1FFC, 32'hFFFF_FF00, 4'b1110, rword, lat);
      chk("mbox_keep", {31'b0, intr}, 32'd1);
      wb_cycle(1'b1, 32'h0000_1FFC, 32'h0000_0000, 4'b0001, rword, lat);
      chk("mbox_clear", {31'b0, intr}, 32'd0);

      // Chip select released before nwe: the write must be abandoned.
      wb_cycle(1'b1, 32'h0050, 32'h1234_5678, 4'hF, rword, lat);
      cpu_addr = 13'h0050; cpu_data_i = 8'h00; cpu_ncs = 1'b0; cpu_nwe = 1'b0;
      repeat (5) @(posedge clk); #1;
      cpu_ncs = 1'b1;
      repeat (5) @(posedge clk); #1;
      cpu_nwe = 1'b1;
      repeat (5) @(posedge clk); #1;
      $display("txn host_write_aborted addr=0050");
      exp_q.push_back(32'h1234_5678);
      wb_cycle(1'b0, 32'h0050, 32'd0, 4'hF, rword, lat);
      expw = exp_q.pop_front();
      chk("abort_keep", rword, expw);

      // Reset in the middle of a host write, with intr set beforehand.
      host_write(13'h1FFF, 8'hA5);
      chk("mbox_set2", {31'b0, intr}, 32'd1);
      wb_cycle(1'b1, 32'h0060, 32'h8765_4321, 4'hF, rword, lat);
      cpu_addr = 13'h0060; cpu_data_i = 8'h11; cpu_ncs = 1'b0; cpu_nwe = 1'b0;
      repeat (5) @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk); #1;
      cpu_nwe = 1'b1; cpu_ncs = 1'b1;
      repeat (4) @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rst2_ack",   {31'b0, wb_ack_o}, 32'd0);
      chk("rst2_wbdat", wb_dat_o, 32'd0);
      chk("rst2_cpudo", {24'b0, cpu_data_o}, 32'd0);
      chk("rst2_oe",    {31'b0, cpu_data_oe}, 32'd0);
      chk("rst2_intr",  {31'b0, intr}, 32'd0);
      repeat (4) @(posedge clk); #1;
      $display("txn reset_mid_write addr=0060");
      exp_q.push_back(32'h8765_4321);
      wb_cycle(1'b0, 32'h0060, 32'd0, 4'hF, rword, lat);
      expw = exp_q.pop_front();
      chk("rst2_keep", rword, expw);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_hostbridge.md
WB_HOSTBRIDGE -- requirements
Module: wb_hostbridge

Interface
REQ-001 Parameter: adr_width, default 11; word-address width of the shared buffer (2^adr_width x 32 bit).
REQ-002 Parameter: sync_stages, default 2; synchronizer depth on the host strobes.
REQ-003 clk  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 wb_adr_i  in  32  Wishbone byte address; bits [adr_width+1:2] select the word.
REQ-006 wb_dat_i  in  32  Wishbone write data.
REQ-007 wb_dat_o  out  32  Wishbone read data.
REQ-008 wb_sel_i  in  4  byte enables; sel[3] = bits 31:24.
REQ-009 wb_stb_i, wb_cyc_i, wb_we_i  in  1 each  Wishbone strobe, cycle, write enable.
REQ-010 wb_ack_o  out  1  Wishbone acknowledge.
REQ-011 cpu_addr  in  13  host byte address, asynchronous to clk.
REQ-012 cpu_data_i  in  8  host write data.
REQ-013 cpu_data_o  out  8  host read data.
REQ-014 cpu_data_oe  out  1  host data-bus output enable.
REQ-015 cpu_nwe, cpu_noe, cpu_ncs  in  1 each  active-low host write, read, chip-select strobes.
REQ-016 intr  out  1  mailbox interrupt to the LM32, active-high.

Function
REQ-017 Buffer byte mapping SHALL be big-endian: host byte address A maps to word A[12:2], lane 3-A[1:0] (lane 3 = bits 31:24).
REQ-018 cpu_nwe, cpu_noe, cpu_ncs SHALL pass through sync_stages flops before use; cpu_addr and cpu_data_i SHALL be registered every cycle while synced nwe is low.
REQ-019 Host FSM states: H_IDLE, H_WRITE, H_READ.
REQ-020 H_IDLE -> H_WRITE when synced ncs=0 and nwe=0; H_IDLE -> H_READ when synced ncs=0, noe=0, nwe=1.
REQ-021 In H_WRITE, a rising edge of synced nwe SHALL produce exactly one byte commit of the last captured data/address, then return to H_IDLE; ncs rising first SHALL abort without a commit.
REQ-022 In H_READ, cpu_data_o SHALL present the addressed byte and cpu_data_oe=1 from the second cycle in H_READ until synced noe or ncs goes high, then return to H_IDLE with cpu_data_oe=0 in the same cycle.
REQ-023 Wishbone FSM states: W_IDLE, W_ACK; W_IDLE -> W_ACK when stb&cyc and no host commit in that cycle; W_ACK -> W_IDLE unconditionally.
REQ-024 wb_ack_o SHALL be high exactly during the W_ACK cycle; nominal latency is 1 cycle after stb&cyc, and ack SHALL never be high in two consecutive cycles.
REQ-025 Wishbone writes SHALL update only the lanes with sel=1; reads SHALL return the full word in wb_dat_o, valid while ack=1.
REQ-026 Host commit SHALL have priority; a coincident Wishbone request SHALL be delayed one cycle (latency 2), never dropped.
REQ-027 A Wishbone write and a later host commit to the same byte SHALL leave the host value; a read in the cycle after a commit SHALL return the committed byte.
REQ-028 A host commit to byte address 0x1FFF SHALL set intr=1 on the following cycle.
REQ-029 intr SHALL clear on a Wishbone write to word 0x7FF with sel[0]=1; if a set and a clear coincide, the set SHALL win.
REQ-030 Addresses beyond 2^adr_width words SHALL wrap (upper bits ignored).

Reset
REQ-031 Reset SHALL force: wb_ack_o=0, wb_dat_o=0, cpu_data_o=0, cpu_data_oe=0, intr=0, both FSMs to idle, synchronizer flops to 1 (inactive).
REQ-032 Buffer contents SHALL NOT be cleared by reset.
REQ-033 Reset asserted during H_WRITE SHALL discard the pending commit; reset during W_ACK SHALL drop the ack.

Structure
REQ-034 A shared package SHALL hold: host FSM and Wishbone FSM state typedefs, the mailbox byte address constant 13'h1FFF, and the byte-lane mapping constants.
REQ-035 A single sub-module, hostbridge_sync, SHALL implement the strobe synchronizer and rising-edge detection; the buffer SHALL be an inferred single-clock RAM.

Verification
REQ-036 Host writes 0xDE,0xAD,0xBE,0xEF to bytes 0-3 -> Wishbone read of word 0 returns 0xDEADBEEF with ack 1 cycle after stb.
REQ-037 Wishbone writes 0x11223344 to word 5 with sel=4'b0101 over 0xFFFFFFFF -> host reads of bytes 0x14-0x17 return FF,22,FF,44.
REQ-038 Host nwe rise coincides with Wishbone stb -> ack arrives after 2 cycles and the host byte is committed.
REQ-039 Host writes 0x5A to byte 0x1FFF -> intr=1; Wishbone write to word 0x7FF with sel=4'b0001 -> intr=0 next cycle.
REQ-040 Reset asserted mid-H_WRITE, then nwe released -> no byte changes, and all outputs are 0.
REQ-041 Host write with ncs deasserted before nwe -> no commit; the target byte keeps its prior value.
